sdram_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system-bus request/response port of the SDRAM controller between `NP` independent requesters (e.g. CPU, DMA, video fetch). It sits directly in front of the controller's `bus_req_*` / `bus_rsp_*` interface. It grants one requester at a time, holds the grant across a complete burst, and tracks outstanding reads in a tag FIFO so each read-data beat returns to the port that issued it.

---
 rtl/sdram_pkg.sv | 11 +
 rtl/sdram_rsp_tag_fifo.sv | 40 ++++
 rtl/sdram_bus_arbiter.sv | 104 ++++++++++
 tb/tb_sdram_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: shared types and helpers for the SDRAM bus arbiter slice
package sdram_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  typedef struct packed {
    logic [1:0] id;
    logic [3:0] beats;
  } rsp_tag_t;
  function automatic logic [3:0] burst_beats(input logic burst, input logic [2:0] len);
    return !burst ? 4'd1 : len[2] ? 4'd8 : 4'd1 << len[1:0];
  endfunction
endpackage

// File: rtl/sdram_rsp_tag_fifo.sv
// sdram_rsp_tag_fifo: outstanding-read tag queue, head beat count decremented in place
module sdram_rsp_tag_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  rsp_tag_t push_tag,
  input  logic     rsp,
  output rsp_tag_t head,
  output logic     full,
  output logic     empty
);
  localparam int PW = $clog2(DEPTH);
  rsp_tag_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (PW + 1)'(DEPTH);
  assign head = mem[rd_ptr];
  assign do_pop = rsp & ~empty & (head.beats == 4'd1);
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(do_pop);
      wr_ptr <= wr_ptr + PW'(do_push);
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
    if (rsp & ~empty & ~do_pop) mem[rd_ptr].beats <= head.beats - 4'd1;
  end
endmodule

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter: round-robin share of the SDRAM controller bus port with read-tag routing
module sdram_bus_arbiter
  import sdram_pkg::*;
#(
  parameter int NP = 2,
  parameter int AW = 24,
  parameter int DW = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NP-1:0]           port_req_read,
  input  logic [NP-1:0]           port_req_write,
  input  logic [NP*AW-1:0]        port_req_addr,
  input  logic [NP-1:0]           port_req_burst,
  input  logic [NP*3-1:0]         port_req_burst_len,
  input  logic [NP*DW-1:0]        port_req_wdata,
  input  logic [NP*DW/8-1:0]      port_req_byteenable,
  output logic [NP-1:0]           port_req_ready,
  output logic [NP-1:0]           port_rsp_valid,
  output logic [DW-1:0]           port_rsp_rdata,
  output logic                    bus_req_read,
  output logic                    bus_req_write,
  output logic                    bus_req_burst,
  output logic [AW-1:0]           bus_req_addr,
  output logic [2:0]              bus_req_burst_len,
  output logic [DW-1:0]           bus_req_wdata,
  output logic [DW/8-1:0]         bus_req_byteenable,
  input  logic                    bus_req_ready,
  input  logic                    bus_rsp_valid,
  input  logic [DW-1:0]           bus_rsp_rdata,
  output logic [$clog2(NP)-1:0]   grant_id,
  output logic                    err_orphan_rsp
);
  localparam int GW = $clog2(NP);
  localparam int BW = DW / 8;
  arb_state_e state, state_n;
  logic [GW-1:0] rr_ptr, rr_ptr_n, grant_n, win, g_next;
  logic [2:0] beat_cnt, beat_cnt_n;
  logic [NP-1:0] elig;
  logic any, g_rd, g_wr, hs, push, done, full, empty, rsp_hit;
  logic [3:0] g_beats;
  rsp_tag_t head, push_tag;
  assign elig = port_req_write | (port_req_read & {NP{~full}});
  // scan from the highest offset down so the port nearest rr_ptr wins
  always_comb begin
    win = rr_ptr;
    any = 1'b0;
    for (int k = NP - 1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NP]) begin
        win = GW'((int'(rr_ptr) + k) % NP);
        any = 1'b1;
      end
  end
  always_comb begin
    g_rd = port_req_read[grant_id];
    g_wr = port_req_write[grant_id];
    g_beats = burst_beats(port_req_burst[grant_id], port_req_burst_len[grant_id*3 +: 3]);
    hs = (state == BUSY) & bus_req_ready;
    push = hs & g_rd;
    done = (state == BUSY) & (~(g_rd | g_wr) | push | (hs & g_wr & (beat_cnt == 3'(g_beats - 4'd1))));
    g_next = (int'(grant_id) == NP - 1) ? '0 : grant_id + 1'b1;
    state_n = (state == IDLE) ? (any ? BUSY : IDLE) : (done ? IDLE : BUSY);
    grant_n = (state == IDLE && any) ? win : grant_id;
    rr_ptr_n = done ? g_next : rr_ptr;
    beat_cnt_n = (state == IDLE) ? '0 : beat_cnt + 3'(hs & g_wr);
    push_tag = '{id: 2'(grant_id), beats: g_beats};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      err_orphan_rsp <= 1'b0;
    end else begin
      state <= state_n;
      grant_id <= grant_n;
      rr_ptr <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      err_orphan_rsp <= err_orphan_rsp | (bus_rsp_valid & empty);
    end
  sdram_rsp_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_tag(push_tag),
    .rsp(bus_rsp_valid),
    .head(head),
    .full(full),
    .empty(empty)
  );
  assign bus_req_read = (state == BUSY) & g_rd;
  assign bus_req_write = (state == BUSY) & g_wr;
  assign bus_req_burst = port_req_burst[grant_id];
  assign bus_req_addr = port_req_addr[grant_id*AW +: AW];
  assign bus_req_burst_len = port_req_burst_len[grant_id*3 +: 3];
  assign bus_req_wdata = port_req_wdata[grant_id*DW +: DW];
  assign bus_req_byteenable = port_req_byteenable[grant_id*BW +: BW];
  assign port_req_ready = hs ? NP'(1) << grant_id : '0;
  assign rsp_hit = bus_rsp_valid & ~empty;
  assign port_rsp_valid = rsp_hit ? NP'(1) << head.id : '0;
  assign port_rsp_rdata = bus_rsp_rdata;
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// tb_sdram_bus_arbiter: random and directed requesters checked against a queue-based arbiter model
module tb_sdram_bus_arbiter;
  localparam int NP = 2, AW = 24, DW = 16, BW = DW / 8, TAG_DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [NP-1:0] port_req_read, port_req_write, port_req_burst, port_req_ready, port_rsp_valid;
  logic [NP*AW-1:0] port_req_addr;
  logic [NP*3-1:0] port_req_burst_len;
  logic [NP*DW-1:0] port_req_wdata;
  logic [NP*BW-1:0] port_req_byteenable;
  logic [DW-1:0] port_rsp_rdata, bus_req_wdata, bus_rsp_rdata;
  logic bus_req_read, bus_req_write, bus_req_burst, bus_req_ready, bus_rsp_valid, err_orphan_rsp;
  logic [AW-1:0] bus_req_addr;
  logic [2:0] bus_req_burst_len;
  logic [BW-1:0] bus_req_byteenable;
  logic [$clog2(NP)-1:0] grant_id;

  sdram_bus_arbiter #(.NP(NP), .AW(AW), .DW(DW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .port_req_read(port_req_read), .port_req_write(port_req_write),
    .port_req_addr(port_req_addr), .port_req_burst(port_req_burst),
    .port_req_burst_len(port_req_burst_len), .port_req_wdata(port_req_wdata),
    .port_req_byteenable(port_req_byteenable), .port_req_ready(port_req_ready),
    .port_rsp_valid(port_rsp_valid), .port_rsp_rdata(port_rsp_rdata),
    .bus_req_read(bus_req_read), .bus_req_write(bus_req_write), .bus_req_burst(bus_req_burst),
    .bus_req_addr(bus_req_addr), .bus_req_burst_len(bus_req_burst_len),
    .bus_req_wdata(bus_req_wdata), .bus_req_byteenable(bus_req_byteenable),
    .bus_req_ready(bus_req_ready), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
    .grant_id(grant_id), .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic int nbeats(input bit b, input logic [2:0] l);
    return !b ? 1 : (l >= 3'd4 ? 8 : 1 << l);
  endfunction

  // requesters: r_n pending requests with identical fields, r_left beats left in a write
  int r_n[NP], r_left[NP];
  bit r_rd[NP], r_burst[NP];
  logic [2:0] r_len[NP];
  logic [AW-1:0] r_addr[NP];
  logic [DW-1:0] r_wdata[NP];
  logic [BW-1:0] r_be[NP];
  int rdy_prob = 100, rsp_prob = 0, force_n = 0;
  logic [DW-1:0] force_data = '0;
  bit rand_en = 0, run = 0;
  logic [NP-1:0] last_ready = '0;

  typedef struct {int id; int beats;} tag_t;
  tag_t tq[$];
  bit m_busy = 0, m_err = 0;
  int m_gid = 0, m_rr = 0, m_cnt = 0;
  int gq[$];

  task automatic req(input int p, input bit rd, input int n, input bit b, input logic [2:0] l, input logic [AW-1:0] a);
    r_rd[p] = rd; r_burst[p] = b; r_len[p] = l; r_addr[p] = a;
    r_wdata[p] = DW'($urandom); r_be[p] = BW'($urandom);
    r_left[p] = nbeats(b, l); r_n[p] = n;
  endtask

  task automatic apply();
    for (int p = 0; p < NP; p++) begin
      port_req_read[p] = r_n[p] > 0 && r_rd[p];
      port_req_write[p] = r_n[p] > 0 && !r_rd[p];
      port_req_burst[p] = r_burst[p];
      port_req_burst_len[p*3 +: 3] = r_len[p];
      port_req_addr[p*AW +: AW] = r_addr[p];
      port_req_wdata[p*DW +: DW] = r_wdata[p];
      port_req_byteenable[p*BW +: BW] = r_be[p];
    end
    bus_req_ready = $urandom_range(0, 99) < rdy_prob;
    if (force_n > 0) begin
      bus_rsp_valid = 1'b1;
      bus_rsp_rdata = force_data;
      force_n--;
    end else begin
      bus_rsp_valid = tq.size() > 0 && $urandom_range(0, 99) < rsp_prob;
      bus_rsp_rdata = DW'($urandom);
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      r_n[p] = 0; r_left[p] = 0; r_rd[p] = 0; r_burst[p] = 0;
      r_len[p] = '0; r_addr[p] = '0; r_wdata[p] = '0; r_be[p] = '0;
    end
    apply();
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (r_n[p] > 0 && last_ready[p]) begin
          if (r_rd[p]) r_n[p]--;
          else begin
            r_left[p]--;
            if (r_left[p] == 0) begin r_n[p]--; r_left[p] = nbeats(r_burst[p], r_len[p]); end
          end
          r_wdata[p] = DW'($urandom);
        end else if (r_n[p] > 0 && rand_en && $urandom_range(0, 60) == 0) r_n[p] = 0;
        else if (r_n[p] == 0 && rand_en && $urandom_range(0, 3) == 0)
          req(p, 1'($urandom), 1, 1'($urandom), 3'($urandom), AW'($urandom));
      end
      apply();
    end
  end

  // single compare process: model outputs from current state + inputs, then advance the model
  always @(negedge clk) if (run) begin : cmp
    int g, sz, nb, p;
    bit rd, wr, rel, found;
    if (rst) begin
      chk("rst_ready", port_req_ready, 0);
      chk("rst_rsp_valid", port_rsp_valid, 0);
      chk("rst_bus_rw", {bus_req_read, bus_req_write}, 0);
      chk("rst_err", err_orphan_rsp, 0);
      tq.delete(); m_busy = 0; m_err = 0; m_gid = 0; m_rr = 0; m_cnt = 0;
      last_ready = '0;
    end else begin
      g = m_gid;
      rd = port_req_read[g];
      wr = port_req_write[g];
      sz = tq.size();
      chk("grant_id", grant_id, g);
      chk("bus_read", bus_req_read, m_busy && rd);
      chk("bus_write", bus_req_write, m_busy && wr);
      chk("port_ready", port_req_ready, (m_busy && bus_req_ready) ? (1 << g) : 0);
      chk("rsp_valid", port_rsp_valid, (bus_rsp_valid && sz > 0) ? (1 << tq[0].id) : 0);
      chk("rsp_rdata", port_rsp_rdata, bus_rsp_rdata);
      chk("err_orphan", err_orphan_rsp, m_err);
      if (m_busy) begin
        chk("bus_addr", bus_req_addr, port_req_addr[g*AW +: AW]);
        chk("bus_burst", {bus_req_burst, bus_req_burst_len}, {port_req_burst[g], port_req_burst_len[g*3 +: 3]});
        chk("bus_wdata", {bus_req_byteenable, bus_req_wdata}, {port_req_byteenable[g*BW +: BW], port_req_wdata[g*DW +: DW]});
      end
      if (bus_rsp_valid) begin
        if (sz == 0) m_err = 1;
        else begin
          tq[0].beats = tq[0].beats - 1;
          if (tq[0].beats == 0) void'(tq.pop_front());
        end
      end
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NP; k++) begin
          p = (m_rr + k) % NP;
          if (!found && (port_req_write[p] || (port_req_read[p] && sz < TAG_DEPTH))) begin
            m_gid = p; m_busy = 1; found = 1; m_cnt = 0;
          end
        end
      end else begin
        rel = 0;
        nb = nbeats(port_req_burst[g], port_req_burst_len[g*3 +: 3]);
        if (!rd && !wr) rel = 1;
        else if (bus_req_ready) begin
          if (rd) begin tq.push_back('{g, nb}); rel = 1; end
          else begin m_cnt++; if (m_cnt == nb) rel = 1; end
        end
        if (rel) begin m_busy = 0; m_rr = (g + 1) % NP; m_cnt = 0; end
      end
      last_ready = port_req_ready;
    end
  end

  task automatic collect(input int n, input int maxc);
    int c = 0;
    gq.delete();
    while (gq.size() < n && c < maxc) begin
      @(negedge clk);
      c++;
      if (|port_req_ready) gq.push_back(int'(grant_id));
    end
    chk("collect_timeout", gq.size(), n);
  endtask

  function automatic int gq_at(input int i);
    return i < gq.size() ? gq[i] : -1;
  endfunction

  function automatic bit idle_now();
    for (int p = 0; p < NP; p++) if (r_n[p] != 0) return 0;
    return tq.size() == 0 && !m_busy;
  endfunction

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (c < maxc && !idle_now()) begin @(negedge clk); #2; c++; end
    chk("idle_timeout", idle_now(), 1);
  endtask

  initial begin
    #1 rst = 1; run = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_grant", grant_id, 0);
    chk("reset_err", err_orphan_rsp, 0);
    // single non-burst read from port 0
    req(0, 1, 1, 0, 3'd0, 24'h000100);
    @(negedge clk);
    chk("rd_bubble", bus_req_read, 0);
    @(negedge clk);
    chk("rd_issue", bus_req_read, 1);
    chk("rd_addr", bus_req_addr, 24'h000100);
    chk("rd_ready", port_req_ready, 2'b01);
    force_data = 16'hBEEF; force_n = 1;
    @(negedge clk);
    chk("rd_rsp_valid", port_rsp_valid, 2'b01);
    chk("rd_rsp_data", port_rsp_rdata, 16'hBEEF);
    wait_idle(20);
    // two continuous writers alternate, port 1 first after port 0's grant
    req(0, 0, 6, 0, 3'd0, 24'h10);
    req(1, 0, 6, 0, 3'd0, 24'h20);
    collect(6, 60);
    for (int i = 0; i < 6; i++) chk("alternate", gq_at(i), (i + 1) % 2);
    wait_idle(60);
    // 4-beat write burst from port 1 holds the grant over port 0
    rdy_prob = 50;
    req(1, 0, 1, 1, 3'd2, 24'h30);
    req(0, 0, 1, 0, 3'd0, 24'h40);
    collect(5, 80);
    for (int i = 0; i < 5; i++) chk("burst_hold", gq_at(i), i < 4 ? 1 : 0);
    wait_idle(40);
    // fill the tag FIFO; reads block but writes still pass
    rdy_prob = 100; rsp_prob = 0;
    req(0, 1, 5, 0, 3'd0, 24'h50);
    collect(4, 40);
    repeat (6) begin @(negedge clk); chk("full_no_read", bus_req_read, 0); end
    req(1, 0, 1, 0, 3'd0, 24'h60);
    collect(1, 10);
    chk("full_write_grant", gq_at(0), 1);
    force_n = 1;
    collect(1, 10);
    chk("slot_freed_grant", gq_at(0), 0);
    rsp_prob = 100;
    wait_idle(40);
    // interleaved routing: 2 beats for port 0 then 1 for port 1
    rsp_prob = 0;
    req(0, 1, 1, 1, 3'd1, 24'h70);
    collect(1, 10);
    chk("il_grant0", gq_at(0), 0);
    req(1, 1, 1, 0, 3'd0, 24'h80);
    collect(1, 10);
    chk("il_grant1", gq_at(0), 1);
    force_data = 16'h1234; force_n = 3;
    @(negedge clk); chk("il_beat0", port_rsp_valid, 2'b01);
    @(negedge clk); chk("il_beat1", port_rsp_valid, 2'b01);
    @(negedge clk); chk("il_beat2", port_rsp_valid, 2'b10);
    wait_idle(20);
    // randomized traffic: responsive controller, then a slow one that fills the FIFO
    rand_en = 1; rdy_prob = 70; rsp_prob = 50;
    repeat (1500) @(negedge clk);
    rdy_prob = 80; rsp_prob = 8;
    repeat (1500) @(negedge clk);
    rand_en = 0; rdy_prob = 100; rsp_prob = 100;
    wait_idle(400);
    // orphan response
    rsp_prob = 0;
    force_n = 1;
    @(negedge clk); chk("orphan_dropped", port_rsp_valid, 0);
    @(negedge clk); chk("orphan_err", err_orphan_rsp, 1);
    // asynchronous reset in the middle of an 8-beat write burst
    req(0, 0, 1, 1, 3'd3, 24'h90);
    collect(2, 20);
    #1 rst = 1;
    for (int p = 0; p < NP; p++) r_n[p] = 0;
    #1;
    chk("rst_mid_write", bus_req_write, 0);
    chk("rst_mid_ready", port_req_ready, 0);
    chk("rst_mid_grant", grant_id, 0);
    chk("rst_mid_err", err_orphan_rsp, 0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
